stream_demux_n: RTL
===================

Name: stream_demux_n

Overview:
- Parametrised, registered 1-to-N stream demultiplexer; successor to the combinational 1:4 bit demux.
- Routes a W-bit data beat on a valid/ready input stream to one of N registered output channels.
- Routing is either by a per-beat select field or by internal round-robin rotation.
- Sits between a single producer and N independent consumers; each channel has its own one-entry output register, so one stalled consumer blocks only the beats addressed to it.

Parameters:
- W, 8, data width in bits.
- N, 4, number of output channels (2..16).
- SELW, 2, select width; must satisfy 2**SELW >= N.
- RR_MODE, 0, 0 = route by in_sel; 1 = round-robin, in_sel ignored.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  W  input beat.
- in_sel  in  SELW  destination channel (RR_MODE=0 only).
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept beat this cycle.
- out_data  out  N*W  channel k occupies bits [k*W +: W].
- out_valid  out  N  per-channel beat valid.
- out_ready  in  N  per-channel consumer ready.
- drop_cnt  out  8  count of beats dropped for out-of-range select, saturating at 255.
- rr_ptr  out  SELW  current round-robin target; 0 when RR_MODE=0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid = 0, all out_data = 0, drop_cnt = 0, rr_ptr = 0.
  - Reset takes priority over every other event, including an in-flight handshake; beats held in output registers are discarded.
- Target channel t:
  - RR_MODE=0: t = in_sel.
  - RR_MODE=1: t = rr_ptr.
- Invalid target: RR_MODE=0 and in_sel >= N.
  - in_ready = 1.
  - An accepted beat is dropped and drop_cnt increments, saturating at 255.
  - No output changes.
- Valid target: in_ready = ~out_valid[t] | out_ready[t]. This is combinational from in_sel, rr_ptr, out_valid and out_ready; there is no combinational path from in_data.
- Accept: in_valid & in_ready at the clk edge.
  - On the next edge, out_data[t] <= in_data and out_valid[t] <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Output consume: out_valid[k] & out_ready[k] at an edge.
  - If no new beat is accepted for channel k on the same edge, out_valid[k] <= 0 and out_data[k] <= 0. Idle channels always present zero data, as the combinational demux did.
  - Simultaneous consume and accept on the same channel: the new beat is loaded and out_valid[k] stays 1. This gives full throughput of one beat per cycle per channel.
- Holding: while out_valid[k] = 1 and out_ready[k] = 0, out_data[k] and out_valid[k] are stable.
- Round-robin pointer:
  - Advances only on accept: rr_ptr <= (rr_ptr == N-1) ? 0 : rr_ptr + 1.
  - Wrap is at N-1, not at 2**SELW-1.
  - A stall on the target channel blocks the input; the pointer does not skip a busy channel.
- Only one channel is loaded per cycle. Other channels may be consumed concurrently and independently.
- in_valid deasserted: no state change except output consumes.
- Input protocol: in_data and in_sel are sampled only on accept. The producer must hold in_data/in_sel stable while in_valid=1 and in_ready=0; the block does not check this.

Test Plan:
1. Reset, then RR_MODE=0, N=4, W=8:
   - Send 0xA5 with sel=2, all out_ready=1.
   - Cycle after accept: out_valid=4'b0100, channel 2 data = 0xA5, others 0.
   - Next cycle: out_valid=0 and all data 0.
2. Backpressure:
   - Hold out_ready[1]=0 and send 0x11 to sel=1, then 0x22 to sel=1.
   - Second beat sees in_ready=0 and out_data[1] holds 0x11.
   - Meanwhile 0x33 to sel=3 is accepted.
   - Raise out_ready[1]: 0x22 appears the cycle after its accept.
3. Full throughput: out_ready[0]=1, stream 0x01..0x08 to sel=0 with in_valid=1 continuously -> in_ready=1 every cycle; channel 0 shows 0x01..0x08 on consecutive cycles with out_valid[0]=1 throughout.
4. Out-of-range select, N=3, SELW=2:
   - Send 300 beats with sel=3 -> in_ready=1, no out_valid ever asserted, drop_cnt saturates at 255.
   - A beat to sel=0 then routes normally.
5. Round-robin, RR_MODE=1, N=3:
   - Send 7 beats 0x10..0x16 with random in_sel -> channels receive 0,1,2,0,1,2,0 in order.
   - rr_ptr ends at 1.
   - Stalling channel 1 stalls the input at beat 0x11, and rr_ptr stays 1.
6. Reset mid-operation:
   - With channel 2 holding an unconsumed beat and rr_ptr=2, assert rst_n=0 for one edge.
   - out_valid=0, data 0, drop_cnt=0, rr_ptr=0.
   - The first post-reset beat goes to channel 0 in RR_MODE=1.

Source files
------------

// File: rtl/stream_demux_n.sv
// rtl/stream_demux_n.sv - registered 1-to-N valid/ready stream demultiplexer
//
// Purpose:
//   Routes each W-bit beat from a single producer to one of N independently
//   registered output channels. Routing is either by the per-beat in_sel
//   field (RR_MODE=0) or by an internal round-robin pointer (RR_MODE=1).
//   Each channel owns a one-entry output register, so a stalled consumer
//   only blocks beats addressed to it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    input beat
//   in_sel     destination channel (ignored when RR_MODE=1)
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle
//   out_data   channel k occupies bits [k*W +: W]; zero while idle
//   out_valid  per-channel beat valid
//   out_ready  per-channel consumer ready
//   drop_cnt   beats dropped for out-of-range select, saturates at 255
//   rr_ptr     current round-robin target (0 when RR_MODE=0)

module stream_demux_n #(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int SELW    = 2,
    parameter int RR_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    in_data,
    input  logic [SELW-1:0] in_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N*W-1:0]  out_data,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [7:0]      drop_cnt,
    output logic [SELW-1:0] rr_ptr
);

    localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] tgt;
    logic            tgt_ok;
    logic            tgt_free;
    logic            accept;
    logic [N-1:0]    load;
    logic [N*W-1:0]  data_q;
    logic [N-1:0]    valid_q;
    logic [7:0]      drop_q;

    assign tgt    = (RR_MODE != 0) ? ptr_q : in_sel;
    assign tgt_ok = ({1'b0, tgt} < N_EXT);

    // Per-channel decode done as a loop so an out-of-range select never
    // indexes past the end of the channel vectors.
    always_comb begin
        tgt_free = 1'b0;
        load     = '0;
        for (int k = 0; k < N; k++) begin
            if (tgt == SELW'(k)) begin
                tgt_free = ~valid_q[k] | out_ready[k];
            end
        end
        // Out-of-range targets are always accepted (and then dropped).
        in_ready = tgt_ok ? tgt_free : 1'b1;
        accept   = in_valid & in_ready;
        for (int k = 0; k < N; k++) begin
            load[k] = accept & tgt_ok & (tgt == SELW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    // A same-edge consume is absorbed: the new beat replaces it.
                    data_q[k*W +: W] <= in_data;
                    valid_q[k]       <= 1'b1;
                end else if (valid_q[k] && out_ready[k]) begin
                    // Idle channels present zero data.
                    data_q[k*W +: W] <= '0;
                    valid_q[k]       <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (accept && !tgt_ok && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    // The pointer moves only on an accepted beat, so a busy target stalls the
    // input rather than being skipped. Wrap is at N-1, not at 2**SELW-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if ((RR_MODE != 0) && accept) begin
            ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + SELW'(1);
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;
    assign rr_ptr    = ptr_q;

endmodule
